// File: rtl/packet_tx_reader.sv
// Reads queued packets out of the packet RAM and frames them for the MAC:
// preamble + SFD, payload from the read pointer, then the inter-frame gap.
module packet_tx_reader #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pDEPTH_RAM         = 2*pMAX_PACKET_LENGHT,
  parameter int pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT),
  parameter int pIFG               = 12
) (
  input  logic                          iclk,
  input  logic                          i_rst,
  input  logic                          i_tx_enable,
  input  logic                          i_fifo_empty,
  input  logic [pLEN_WIDTH-1:0]         i_fifo_len,
  output logic                          o_fifo_rd,
  output logic [$clog2(pDEPTH_RAM)-1:0] o_rd_addr,
  input  logic [pDATA_WIDTH-1:0]        i_rd_data,
  output logic [pDATA_WIDTH-1:0]        otx_d,
  output logic                          otx_en,
  output logic [$clog2(pDEPTH_RAM)-1:0] o_rd_ptr,
  output logic                          o_busy,
  output logic                          o_pkt_done,
  output logic                          o_len_err
);

  // state    | meaning
  // IDLE     | waiting for enable + queued length; pops FIFO, discards bad lengths
  // PREAMBLE | 7 x 0x55 then 0xD5, first payload byte is being fetched
  // DATA     | one payload byte per cycle straight from the RAM read port
  // IFG      | line quiet; the following IDLE cycle completes the gap
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_IFG} state_t;

  localparam int AW = $clog2(pDEPTH_RAM);
  localparam int IW = (pIFG > 2) ? $clog2(pIFG) : 1;
  localparam int SW = ((AW > pLEN_WIDTH) ? AW : pLEN_WIDTH) + 1;
  localparam logic [pLEN_WIDTH:0]   MAX_LEN = (pLEN_WIDTH+1)'(pMAX_PACKET_LENGHT);
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE = pLEN_WIDTH'(1);
  localparam logic [AW-1:0]         ADDR_LAST = AW'(pDEPTH_RAM - 1);

  state_t                state, state_nxt;
  logic [2:0]            pre_cnt;
  logic [pLEN_WIDTH-1:0] byte_cnt;
  logic [IW-1:0]         ifg_cnt;
  logic [AW-1:0]         rd_addr, rd_ptr, addr_inc;
  logic                  run_ok;
  logic                  len_ok, pop, discard, last_byte;

  // Lengths are always below the RAM depth, so one conditional subtract wraps.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base,
                                             input logic [pLEN_WIDTH-1:0] n);
    logic [SW-1:0] sum;
    sum = SW'(base) + SW'(n);
    if (sum >= SW'(pDEPTH_RAM)) sum = sum - SW'(pDEPTH_RAM);
    return AW'(sum);
  endfunction

  assign addr_inc  = (rd_addr == ADDR_LAST) ? '0 : rd_addr + AW'(1);
  assign len_ok    = (i_fifo_len != '0) && ({1'b0, i_fifo_len} <= MAX_LEN);
  assign last_byte = (state == ST_DATA) && (byte_cnt == LEN_ONE);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    discard   = 1'b0;
    case (state)
      ST_IDLE: begin
        // run_ok keeps the pop quiet while reset is held and for one cycle after
        if (run_ok && i_tx_enable && !i_fifo_empty) begin
          pop = 1'b1;
          if (len_ok) state_nxt = ST_PREAMBLE;
          else        discard   = 1'b1;
        end
      end
      ST_PREAMBLE: if (pre_cnt == 3'd7) state_nxt = ST_DATA;
      ST_DATA:     if (byte_cnt == LEN_ONE) state_nxt = (pIFG > 1) ? ST_IFG : ST_IDLE;
      ST_IFG:      if (ifg_cnt == '0) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      run_ok   <= 1'b0;
      pre_cnt  <= '0;
      byte_cnt <= '0;
      ifg_cnt  <= '0;
      rd_addr  <= '0;
      rd_ptr   <= '0;
    end else begin
      run_ok <= 1'b1;
      state  <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            byte_cnt <= i_fifo_len;
            pre_cnt  <= '0;
          end
          if (discard) begin
            rd_ptr  <= wrap_add(rd_ptr, i_fifo_len);
            rd_addr <= wrap_add(rd_ptr, i_fifo_len);
          end
        end
        ST_PREAMBLE: begin
          pre_cnt <= pre_cnt + 3'd1;
          if (pre_cnt == 3'd7) rd_addr <= addr_inc;
        end
        ST_DATA: begin
          // rd_addr runs one ahead of the byte on the line, so it already
          // points past the last byte when the count hits one
          if (byte_cnt == LEN_ONE) begin
            rd_ptr  <= rd_addr;
            ifg_cnt <= IW'(pIFG - 2);
          end else begin
            byte_cnt <= byte_cnt - LEN_ONE;
            rd_addr  <= addr_inc;
          end
        end
        ST_IFG: if (ifg_cnt != '0) ifg_cnt <= ifg_cnt - IW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    otx_en = 1'b0;
    otx_d  = '0;
    case (state)
      ST_PREAMBLE: begin
        otx_en = 1'b1;
        otx_d  = (pre_cnt == 3'd7) ? pDATA_WIDTH'(8'hD5) : pDATA_WIDTH'(8'h55);
      end
      ST_DATA: begin
        otx_en = 1'b1;
        otx_d  = i_rd_data;
      end
      default: ;
    endcase
  end

  assign o_fifo_rd  = pop;
  assign o_len_err  = discard;
  assign o_pkt_done = last_byte;
  assign o_busy     = (state != ST_IDLE);
  assign o_rd_addr  = rd_addr;
  assign o_rd_ptr   = rd_ptr;

endmodule

// File: doc/packet_tx_reader.md
PACKET_TX_READER -- requirements
Module: packet_tx_reader

Interface
REQ-001 SHALL have parameter pDATA_WIDTH, default 8, giving the data byte width.
REQ-002 SHALL have parameter pMAX_PACKET_LENGHT, default 1536, giving the largest legal payload length in bytes.
REQ-003 SHALL have parameter pDEPTH_RAM, default 2*pMAX_PACKET_LENGHT, giving the packet RAM depth in bytes.
REQ-004 SHALL have parameter pLEN_WIDTH, default $clog2(pMAX_PACKET_LENGHT), giving the length word width.
REQ-005 SHALL have parameter pIFG, default 12, giving the minimum inter-frame gap in cycles.
REQ-006 SHALL have port iclk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 SHALL have port i_rst, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port i_tx_enable, input, 1 bit: permits the start of a new frame.
REQ-009 SHALL have port i_fifo_empty, input, 1 bit: the length FIFO is empty.
REQ-010 SHALL have port i_fifo_len, input, pLEN_WIDTH bits: the head-of-FIFO packet length, valid while i_fifo_empty=0 (first-word-fall-through).
REQ-011 SHALL have port o_fifo_rd, output, 1 bit: a one-cycle pop of the length FIFO.
REQ-012 SHALL have port o_rd_addr, output, $clog2(pDEPTH_RAM) bits: the packet RAM read address.
REQ-013 SHALL have port i_rd_data, input, pDATA_WIDTH bits: the RAM read data, valid exactly 1 cycle after o_rd_addr.
REQ-014 SHALL have port otx_d, output, pDATA_WIDTH bits: the transmit byte.
REQ-015 SHALL have port otx_en, output, 1 bit: the transmit byte is valid.
REQ-016 SHALL have port o_rd_ptr, output, $clog2(pDEPTH_RAM) bits: the committed read pointer, returned to the writer for space checks.
REQ-017 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-018 SHALL have port o_pkt_done, output, 1 bit: a one-cycle pulse with the last payload byte.
REQ-019 SHALL have port o_len_err, output, 1 bit: a one-cycle pulse when an illegal length is discarded.

Function
REQ-020 SHALL implement the FSM states IDLE, PREAMBLE, DATA and IFG.
REQ-021 In IDLE, when i_tx_enable=1 and i_fifo_empty=0, SHALL pulse o_fifo_rd for one cycle and latch i_fifo_len into the byte counter in the same cycle.
REQ-022 In that IDLE cycle, a latched length of 0 or greater than pMAX_PACKET_LENGHT SHALL be discarded: pulse o_len_err, advance the read pointer by the length modulo pDEPTH_RAM, and remain in IDLE.
REQ-023 In that IDLE cycle, a latched length in 1..pMAX_PACKET_LENGHT SHALL cause the transition to PREAMBLE.
REQ-024 PREAMBLE SHALL last 8 cycles with otx_en=1: otx_d=0x55 for cycles 0..6 and 0xD5 for cycle 7.
REQ-025 RAM reads SHALL be prefetched so that the first payload byte is on otx_d in the cycle immediately after 0xD5.
REQ-026 DATA SHALL drive otx_en=1 and output exactly the latched-length number of consecutive bytes from the read pointer, with no gaps.
REQ-027 o_rd_addr SHALL increment once per byte and wrap from pDEPTH_RAM-1 to 0.
REQ-028 o_pkt_done SHALL be asserted with the last payload byte, followed by the transition to IFG.
REQ-029 o_rd_ptr SHALL update only at frame end (or on a discard), to the address after the last byte, modulo pDEPTH_RAM.
REQ-030 IFG SHALL hold otx_en=0 and otx_d=0 for exactly pIFG cycles and then return to IDLE.
REQ-031 A new frame SHALL NOT start before IFG has completed.
REQ-032 Deassertion of i_tx_enable SHALL only block new frame starts and SHALL NOT truncate a frame in progress.
REQ-033 o_fifo_rd SHALL never be asserted while i_fifo_empty=1, and at most once per frame.
REQ-034 Whenever otx_en=0, otx_d SHALL be 0.
REQ-035 The byte counter SHALL be pLEN_WIDTH bits wide and SHALL NOT underflow; DATA SHALL exit when the count reaches 1.

Reset
REQ-036 i_rst=0 SHALL immediately (asynchronously) force IDLE, otx_en=0, otx_d=0, o_fifo_rd=0, o_pkt_done=0, o_len_err=0, o_busy=0, o_rd_addr=0 and o_rd_ptr=0, and clear all counters.
REQ-037 Reset asserted mid-frame SHALL abort the frame without any further FIFO pop; after reset release, operation SHALL resume from address 0.

Verification
REQ-038 Test: FIFO holds length 64, RAM[0..63]=0..63, i_tx_enable=1 -> otx_en high for exactly 72 cycles (7x0x55, 0xD5, bytes 0x00..0x3F), o_pkt_done with 0x3F, o_rd_ptr=64, then otx_en low for exactly 12 cycles.
REQ-039 Test: with o_rd_ptr=3060 and pDEPTH_RAM=3072, send length 20 -> addresses 3060..3071 then 0..7, o_rd_ptr=8 afterwards.
REQ-040 Test: FIFO holds length 0, then length 1536 -> o_len_err pulses once with no otx_en; then a 1544-cycle frame follows.
REQ-041 Test: two back-to-back lengths of 64 -> the gap between frames is exactly 12 cycles, and o_fifo_rd pulses exactly twice.
REQ-042 Test: i_rst=0 asserted at payload byte 30 -> otx_en=0 in the same cycle, no o_pkt_done, o_rd_ptr=0, FIFO not popped again.
REQ-043 Test: i_tx_enable dropped during DATA -> the frame completes, and no new frame starts until i_tx_enable=1 again.
